// File: rtl/layer_ctrl_pkg.sv
// Shared types and sizing helpers for the layer sequencing controller.
// Counter widths are derived from the layer geometry so the counters never wrap mid-phase.
package layer_ctrl_pkg;

  localparam int N_NEURONS_DEF = 4;
  localparam int K_DEF         = 4;
  localparam int DW_DEF        = 16;
  localparam int MAC_LAT_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COLLECT,
    FIRE,
    RESULT
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_cnt_w(input int n_neurons, input int k);
    return cnt_w(n_neurons * k);
  endfunction

  // Fire counter must reach K+MAC_LAT: one extra step for the capture cycle.
  function automatic int fire_cnt_w(input int k, input int mac_lat);
    return cnt_w(k + mac_lat + 1);
  endfunction

  function automatic int ptr_w(input int k);
    return cnt_w(k);
  endfunction

endpackage

// File: rtl/layer_seq_ctrl_vec_buf.sv
// K-entry input vector buffer: written in order while collecting, read by index while firing.
// Holds pure data, so it carries no reset.
module vec_buf #(
  parameter int K  = 4,
  parameter int DW = 16,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [PW-1:0] wptr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [PW-1:0] rptr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [K];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wptr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_i];

endmodule

// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: streams weights into the neuron RAMs, buffers one input vector,
// fires all neurons in lock-step and hands back their thresholded outputs.
module layer_seq_ctrl
  import layer_ctrl_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int K         = K_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAC_LAT   = MAC_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DW-1:0]        cfg_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic [DW-1:0]        wgt_o,
  output logic [N_NEURONS-1:0] str_wgt_o,
  output logic                 start_o,
  output logic [DW-1:0]        x_o,
  input  logic [N_NEURONS-1:0] y_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] out_data,
  output logic                 wgt_loaded
);

  localparam int BCW = beat_cnt_w(N_NEURONS, K);
  localparam int FCW = fire_cnt_w(K, MAC_LAT);
  localparam int PW  = ptr_w(K);

  localparam logic [BCW-1:0] BEAT_LAST = BCW'(N_NEURONS * K - 1);
  localparam logic [PW-1:0]  IN_LAST   = PW'(K - 1);
  localparam logic [FCW-1:0] FIRE_XEND = FCW'(K);
  localparam logic [FCW-1:0] FIRE_LAST = FCW'(K + MAC_LAT);

  state_e               state_q, state_d;
  logic [BCW-1:0]       beat_q, beat_d;
  logic [PW-1:0]        in_cnt_q, in_cnt_d;
  logic [FCW-1:0]       fire_q, fire_d;
  logic [DW-1:0]        wgt_q, wgt_d;
  logic [N_NEURONS-1:0] str_q, str_d;
  logic                 start_q, start_d;
  logic [DW-1:0]        x_q, x_d;
  logic [N_NEURONS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 loaded_q, loaded_d;

  logic                 cfg_acc;
  logic                 in_acc;
  logic [DW-1:0]        buf_rd;

  // A simultaneous cfg beat in IDLE takes priority, so the input side is held off.
  assign cfg_ready = rst_n & ((state_q == IDLE) | (state_q == LOAD));
  assign in_ready  = rst_n & (((state_q == IDLE) & loaded_q & ~cfg_valid) |
                              (state_q == COLLECT));
  assign cfg_acc   = cfg_valid & cfg_ready;
  assign in_acc    = in_valid & in_ready;

  vec_buf #(
    .K  (K),
    .DW (DW),
    .PW (PW)
  ) u_vec_buf (
    .clk     (clk),
    .we_i    (in_acc),
    .wptr_i  (in_cnt_q),
    .wdata_i (in_data),
    .rptr_i  (fire_q[PW-1:0]),
    .rdata_o (buf_rd)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    in_cnt_d    = in_cnt_q;
    fire_d      = fire_q;
    wgt_d       = wgt_q;
    str_d       = '0;
    start_d     = 1'b0;
    x_d         = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    loaded_d    = loaded_q;

    if (cfg_acc) begin
      wgt_d    = cfg_data;
      loaded_d = 1'b0;
      for (int n = 0; n < N_NEURONS; n++) begin
        str_d[n] = ((int'(beat_q) / K) == n);
      end
      if (beat_q == BEAT_LAST) begin
        beat_d   = '0;
        loaded_d = 1'b1;
        state_d  = IDLE;
      end else begin
        beat_d  = beat_q + 1'b1;
        state_d = LOAD;
      end
    end

    if (in_acc) begin
      if (in_cnt_q == IN_LAST) begin
        in_cnt_d = '0;
        fire_d   = '0;
        state_d  = FIRE;
      end else begin
        in_cnt_d = in_cnt_q + 1'b1;
        state_d  = COLLECT;
      end
    end

    // Start is registered one step behind the fire count; the final count is the
    // cycle the neurons see their last start, so y_i is settled and captured there.
    case (state_q)
      FIRE: begin
        if (fire_q == FIRE_LAST) begin
          out_data_d  = y_i;
          out_valid_d = 1'b1;
          fire_d      = '0;
          state_d     = RESULT;
        end else begin
          start_d = 1'b1;
          x_d     = (fire_q < FIRE_XEND) ? buf_rd : '0;
          fire_d  = fire_q + 1'b1;
        end
      end
      RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      in_cnt_q    <= '0;
      fire_q      <= '0;
      wgt_q       <= '0;
      str_q       <= '0;
      start_q     <= 1'b0;
      x_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      in_cnt_q    <= in_cnt_d;
      fire_q      <= fire_d;
      wgt_q       <= wgt_d;
      str_q       <= str_d;
      start_q     <= start_d;
      x_q         <= x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      loaded_q    <= loaded_d;
    end
  end

  assign wgt_o      = wgt_q;
  assign str_wgt_o  = str_q;
  assign start_o    = start_q;
  assign x_o        = x_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign wgt_loaded = loaded_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for the layer sequencer with a scripted neuron response.
module tb_layer_seq_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] cfg_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] wgt_o;
  logic [N-1:0]  str_wgt_o;
  logic          start_o;
  logic [DW-1:0] x_o;
  logic [N-1:0]  y_i;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          wgt_loaded;

  int n_vec;
  int n_miss;
  int strobes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  layer_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wgt_o      (wgt_o),
    .str_wgt_o  (str_wgt_o),
    .start_o    (start_o),
    .x_o        (x_o),
    .y_i        (y_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .wgt_loaded (wgt_loaded)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_contig();
    for (int b = 0; b < 16; b++) begin
      cfg_valid = 1'b1;
      cfg_data  = DW'(b + 1);
      #1;
      chk("load_cfg_rdy", 32'(cfg_ready), 32'd1);
      tick();
      chk("load_wgt", 32'(wgt_o), 32'(b + 1));
      chk("load_str", 32'(str_wgt_o), 32'd1 << (b / 4));
      if (b < 15) chk("load_busy", 32'(wgt_loaded), 32'd0);
    end
    cfg_valid = 1'b0;
    chk("load_done", 32'(wgt_loaded), 32'd1);
    tick();
    chk("load_str_idle", 32'(str_wgt_o), 32'd0);
    chk("load_still", 32'(wgt_loaded), 32'd1);
  endtask

  task automatic fire_run(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                          input logic [DW-1:0] x2, input logic [DW-1:0] x3,
                          input logic [N-1:0] yres);
    logic [DW-1:0] xv [4];
    logic [DW-1:0] xe;
    xv[0] = x0;
    xv[1] = x1;
    xv[2] = x2;
    xv[3] = x3;
    y_i   = ~yres;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = xv[k];
      #1;
      chk("col_in_rdy", 32'(in_ready), 32'd1);
      chk("col_cfg_rdy", 32'(cfg_ready), 32'(k == 0));
      tick();
    end
    in_valid = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      xe = (t >= 2 && t <= 5) ? xv[t-2] : '0;
      chk("fire_start", 32'(start_o), 32'(t >= 2 && t <= 9));
      chk("fire_x", 32'(x_o), 32'(xe));
      chk("fire_ovld", 32'(out_valid), 32'(t == 10));
      if (t == 9) y_i = yres;
      if (t < 10) tick();
    end
    y_i = ~yres;
    for (int h = 0; h < 5; h++) begin
      chk("res_ovld", 32'(out_valid), 32'd1);
      chk("res_data", 32'(out_data), 32'(yres));
      chk("res_in_rdy", 32'(in_ready), 32'd0);
      chk("res_cfg_rdy", 32'(cfg_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("res_drop", 32'(out_valid), 32'd0);
    chk("idle_in_rdy", 32'(in_ready), 32'd1);
    chk("idle_start", 32'(start_o), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    y_i       = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_rdy", 32'(cfg_ready), 32'd0);
    chk("rst_in_rdy", 32'(in_ready), 32'd0);
    chk("rst_loaded", 32'(wgt_loaded), 32'd0);
    chk("rst_start", 32'(start_o), 32'd0);
    chk("rst_str", 32'(str_wgt_o), 32'd0);
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_odata", 32'(out_data), 32'd0);
    chk("rst_wgt", 32'(wgt_o), 32'd0);
    chk("rst_x", 32'(x_o), 32'd0);

    // Input offered before any weights: must be refused.
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd5;
    #1;
    chk("preload_in_rdy", 32'(in_ready), 32'd0);
    chk("preload_cfg_rdy", 32'(cfg_ready), 32'd1);
    tick();
    tick();
    chk("preload_in_rdy2", 32'(in_ready), 32'd0);
    chk("preload_start", 32'(start_o), 32'd0);
    in_valid = 1'b0;

    load_contig();
    fire_run(16'd2, 16'd0, 16'd0, 16'd0, 4'b1010);

    // cfg and in together in IDLE, then the rest of the image every other cycle.
    cfg_valid = 1'b1;
    cfg_data  = 16'h0100;
    in_valid  = 1'b1;
    in_data   = 16'd7;
    #1;
    chk("both_in_rdy", 32'(in_ready), 32'd0);
    chk("both_cfg_rdy", 32'(cfg_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("both_str", 32'(str_wgt_o), 32'd1);
    chk("both_wgt", 32'(wgt_o), 32'h0100);
    chk("both_loaded", 32'(wgt_loaded), 32'd0);
    chk("both_in_rdy_load", 32'(in_ready), 32'd0);
    strobes = 1;
    for (int c = 1; c < 32; c++) begin
      cfg_valid = (c % 2 == 0);
      cfg_data  = DW'(16'h0100 + c / 2);
      tick();
      if (str_wgt_o != '0) strobes++;
      chk("gap_str", 32'(str_wgt_o), (c % 2 == 0) ? (32'd1 << ((c / 2) / 4)) : 32'd0);
      if (c % 2 == 0) chk("gap_wgt", 32'(wgt_o), 32'(16'h0100 + c / 2));
    end
    cfg_valid = 1'b0;
    chk("gap_count", 32'(strobes), 32'd16);
    chk("gap_loaded", 32'(wgt_loaded), 32'd1);

    fire_run(16'd3, 16'd5, 16'd7, 16'd9, 4'b0110);

    // Reset during the fourth start cycle of a fire.
    y_i = '0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'd1;
      tick();
    end
    in_valid = 1'b0;
    for (int t = 1; t < 5; t++) tick();
    chk("rf_start_pre", 32'(start_o), 32'd1);
    chk("rf_x_pre", 32'(x_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rf_start", 32'(start_o), 32'd0);
    chk("rf_str", 32'(str_wgt_o), 32'd0);
    chk("rf_loaded", 32'(wgt_loaded), 32'd0);
    chk("rf_ovld", 32'(out_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      chk("rf_ovld_after", 32'(out_valid), 32'd0);
      chk("rf_start_after", 32'(start_o), 32'd0);
      tick();
    end
    chk("rf_cfg_rdy", 32'(cfg_ready), 32'd1);
    chk("rf_in_rdy", 32'(in_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
